// File: rtl/warp_rocc_frontend.sv
// Host-side RoCC command/response buffer in front of warp_engine.
// In-order command queue, response credits, response queue and unexpected-response detection.
module warp_rocc_frontend #(
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int RESP_FIFO_DEPTH = 4,
  parameter int MAX_INFLIGHT    = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                host_cmd_valid,
  output logic                                host_cmd_ready,
  input  logic [6:0]                          host_cmd_funct,
  input  logic [4:0]                          host_cmd_rd,
  input  logic                                host_cmd_xd,
  input  logic [DATA_WIDTH-1:0]               host_cmd_rs1_data,
  input  logic [DATA_WIDTH-1:0]               host_cmd_rs2_data,
  output logic                                host_resp_valid,
  input  logic                                host_resp_ready,
  output logic [4:0]                          host_resp_rd,
  output logic [DATA_WIDTH-1:0]               host_resp_data,
  output logic                                eng_cmd_valid,
  input  logic                                eng_cmd_ready,
  output logic [6:0]                          eng_cmd_funct,
  output logic [4:0]                          eng_cmd_rd,
  output logic [DATA_WIDTH-1:0]               eng_cmd_rs1_data,
  output logic [DATA_WIDTH-1:0]               eng_cmd_rs2_data,
  input  logic                                eng_resp_valid,
  output logic                                eng_resp_ready,
  input  logic [4:0]                          eng_resp_rd,
  input  logic [DATA_WIDTH-1:0]               eng_resp_data,
  output logic                                busy,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_cnt,
  output logic                                err_unexpected_resp
);

  localparam int CP_W  = $clog2(CMD_FIFO_DEPTH) + 1;
  localparam int RP_W  = $clog2(RESP_FIFO_DEPTH) + 1;
  localparam int CW    = $clog2(MAX_INFLIGHT + 1);
  localparam int CMP_W = (CW > RP_W) ? CW : RP_W;

  localparam logic [CW-1:0]   MAX_CNT  = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CP_W-1:0] CPTR_ONE = CP_W'(1);
  localparam logic [RP_W-1:0] RPTR_ONE = RP_W'(1);

  typedef struct packed {
    logic [6:0]            funct;
    logic [4:0]            rd;
    logic                  xd;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
  } cmd_t;

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  cmd_t  cmd_mem  [CMD_FIFO_DEPTH];
  resp_t resp_mem [RESP_FIFO_DEPTH];

  logic [CP_W-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [RP_W-1:0] resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
  logic            cmd_full_q, cmd_full_d;
  logic            resp_full_q, resp_full_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  cmd_t            cmd_head;
  resp_t           resp_head;
  logic            cmd_empty, resp_empty;
  logic            cmd_push, cmd_pop, resp_accept, resp_push, resp_pop;
  logic            credit_ok, credit_inc, owed_pos;
  logic [RP_W-1:0] resp_count;

  assign cmd_head   = cmd_mem[cmd_rd_q[CP_W-2:0]];
  assign resp_head  = resp_mem[resp_rd_q[RP_W-2:0]];
  assign cmd_empty  = (cmd_wr_q == cmd_rd_q);
  assign resp_empty = (resp_wr_q == resp_rd_q);

  // A credit-blocked xd head stalls everything behind it to keep strict order.
  assign credit_ok  = !cmd_head.xd || (inflight_q < MAX_CNT);
  assign cmd_push   = host_cmd_valid && !cmd_full_q;
  assign cmd_pop    = eng_cmd_valid && eng_cmd_ready;
  assign credit_inc = cmd_pop && cmd_head.xd;

  // Responses still owed by the engine = credits in use minus responses already buffered.
  assign resp_count  = resp_wr_q - resp_rd_q;
  assign owed_pos    = CMP_W'(inflight_q) > CMP_W'(resp_count);
  assign resp_accept = eng_resp_valid && !resp_full_q;
  assign resp_push   = resp_accept && owed_pos;
  assign resp_pop    = !resp_empty && host_resp_ready;

  always_comb begin
    cmd_wr_d   = cmd_wr_q;
    cmd_rd_d   = cmd_rd_q;
    resp_wr_d  = resp_wr_q;
    resp_rd_d  = resp_rd_q;
    inflight_d = inflight_q;
    if (cmd_push)  cmd_wr_d  = cmd_wr_q + CPTR_ONE;
    if (cmd_pop)   cmd_rd_d  = cmd_rd_q + CPTR_ONE;
    if (resp_push) resp_wr_d = resp_wr_q + RPTR_ONE;
    if (resp_pop)  resp_rd_d = resp_rd_q + RPTR_ONE;
    case ({credit_inc, resp_pop})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
    cmd_full_d  = (cmd_wr_d[CP_W-1] != cmd_rd_d[CP_W-1]) &&
                  (cmd_wr_d[CP_W-2:0] == cmd_rd_d[CP_W-2:0]);
    resp_full_d = (resp_wr_d[RP_W-1] != resp_rd_d[RP_W-1]) &&
                  (resp_wr_d[RP_W-2:0] == resp_rd_d[RP_W-2:0]);
    err_d       = err_q || (resp_accept && !owed_pos);
    busy_d      = (cmd_wr_d != cmd_rd_d) || (inflight_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      resp_wr_q   <= '0;
      resp_rd_q   <= '0;
      cmd_full_q  <= 1'b0;
      resp_full_q <= 1'b0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      resp_wr_q   <= resp_wr_d;
      resp_rd_q   <= resp_rd_d;
      cmd_full_q  <= cmd_full_d;
      resp_full_q <= resp_full_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers define validity and outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_q[CP_W-2:0]] <= '{funct: host_cmd_funct, rd: host_cmd_rd, xd: host_cmd_xd,
                                       rs1: host_cmd_rs1_data, rs2: host_cmd_rs2_data};
    end
    if (resp_push) begin
      resp_mem[resp_wr_q[RP_W-2:0]] <= '{rd: eng_resp_rd, data: eng_resp_data};
    end
  end

  assign host_cmd_ready      = !cmd_full_q;
  assign eng_resp_ready      = !resp_full_q;
  assign eng_cmd_valid       = !cmd_empty && credit_ok;
  assign eng_cmd_funct       = cmd_empty ? '0 : cmd_head.funct;
  assign eng_cmd_rd          = cmd_empty ? '0 : cmd_head.rd;
  assign eng_cmd_rs1_data    = cmd_empty ? '0 : cmd_head.rs1;
  assign eng_cmd_rs2_data    = cmd_empty ? '0 : cmd_head.rs2;
  assign host_resp_valid     = !resp_empty;
  assign host_resp_rd        = resp_empty ? '0 : resp_head.rd;
  assign host_resp_data      = resp_empty ? '0 : resp_head.data;
  assign busy                = busy_q;
  assign inflight_cnt        = inflight_q;
  assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_warp_rocc_frontend.sv
// Scoreboard bench for warp_rocc_frontend: expected engine commands and host responses are
// queued by the stimulus and checked by a negedge monitor; state flags are checked directly.
module tb_warp_rocc_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_cmd_valid, host_cmd_ready, host_cmd_xd;
  logic [6:0]  host_cmd_funct;
  logic [4:0]  host_cmd_rd;
  logic [31:0] host_cmd_rs1_data, host_cmd_rs2_data;
  logic        host_resp_valid, host_resp_ready;
  logic [4:0]  host_resp_rd;
  logic [31:0] host_resp_data;
  logic        eng_cmd_valid, eng_cmd_ready;
  logic [6:0]  eng_cmd_funct;
  logic [4:0]  eng_cmd_rd;
  logic [31:0] eng_cmd_rs1_data, eng_cmd_rs2_data;
  logic        eng_resp_valid, eng_resp_ready;
  logic [4:0]  eng_resp_rd;
  logic [31:0] eng_resp_data;
  logic        busy, err_unexpected_resp;
  logic [2:0]  inflight_cnt;

  typedef struct {
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_cmd_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_resp_t;

  exp_cmd_t  exp_cmd[$];
  exp_resp_t exp_resp[$];
  exp_cmd_t  mon_cmd;
  exp_resp_t mon_resp;
  int total = 0;
  int bad   = 0;

  warp_rocc_frontend #(
    .CMD_FIFO_DEPTH(4), .RESP_FIFO_DEPTH(4), .MAX_INFLIGHT(4), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd_funct(host_cmd_funct), .host_cmd_rd(host_cmd_rd), .host_cmd_xd(host_cmd_xd),
    .host_cmd_rs1_data(host_cmd_rs1_data), .host_cmd_rs2_data(host_cmd_rs2_data),
    .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
    .host_resp_rd(host_resp_rd), .host_resp_data(host_resp_data),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_cmd_funct(eng_cmd_funct), .eng_cmd_rd(eng_cmd_rd),
    .eng_cmd_rs1_data(eng_cmd_rs1_data), .eng_cmd_rs2_data(eng_cmd_rs2_data),
    .eng_resp_valid(eng_resp_valid), .eng_resp_ready(eng_resp_ready),
    .eng_resp_rd(eng_resp_rd), .eng_resp_data(eng_resp_data),
    .busy(busy), .inflight_cnt(inflight_cnt), .err_unexpected_resp(err_unexpected_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake on an output channel must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_cmd_valid && eng_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL eng_cmd_unexpected: got rs1=0x%0h expected no command", eng_cmd_rs1_data);
        end else begin
          mon_cmd = exp_cmd.pop_front();
          check("eng_cmd_rs1", 64'(eng_cmd_rs1_data), 64'(mon_cmd.rs1));
          check("eng_cmd_hdr", 64'({eng_cmd_funct, eng_cmd_rd, eng_cmd_rs2_data}),
                64'({mon_cmd.funct, mon_cmd.rd, mon_cmd.rs2}));
        end
      end
      if (host_resp_valid && host_resp_ready) begin
        if (exp_resp.size() == 0) begin
          total++; bad++;
          $display("FAIL host_resp_unexpected: got rd=%0d data=0x%0h expected no response",
                   host_resp_rd, host_resp_data);
        end else begin
          mon_resp = exp_resp.pop_front();
          check("host_resp", 64'({host_resp_rd, host_resp_data}), 64'({mon_resp.rd, mon_resp.data}));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [6:0] funct, input logic [4:0] rd, input logic xd,
                          input logic [31:0] rs1, input logic [31:0] rs2, input bit expect_issue);
    int n = 0;
    host_cmd_valid    = 1'b1;
    host_cmd_funct    = funct;
    host_cmd_rd       = rd;
    host_cmd_xd       = xd;
    host_cmd_rs1_data = rs1;
    host_cmd_rs2_data = rs2;
    @(negedge clk);
    while (!host_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 64'(host_cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    host_cmd_valid = 1'b0;
    if (expect_issue) exp_cmd.push_back('{funct, rd, rs1, rs2});
  endtask

  task automatic eng_respond(input logic [4:0] rd, input logic [31:0] data, input bit expect_push);
    eng_resp_valid = 1'b1;
    eng_resp_rd    = rd;
    eng_resp_data  = data;
    @(negedge clk);
    check("eng_resp_ready", 64'(eng_resp_ready), 64'(1));
    @(posedge clk);
    #1;
    eng_resp_valid = 1'b0;
    if (expect_push) exp_resp.push_back('{rd, data});
  endtask

  task automatic wait_cmd_drain();
    int n = 0;
    while (exp_cmd.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("cmd_drain", 64'(exp_cmd.size()), 64'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    host_cmd_valid = 1'b0; host_cmd_funct = '0; host_cmd_rd = '0; host_cmd_xd = 1'b0;
    host_cmd_rs1_data = '0; host_cmd_rs2_data = '0;
    host_resp_ready = 1'b0; eng_cmd_ready = 1'b1;
    eng_resp_valid = 1'b0; eng_resp_rd = '0; eng_resp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valids", 64'({eng_cmd_valid, host_resp_valid, busy, err_unexpected_resp}), 64'(0));
    check("rst_data", 64'({eng_cmd_rs1_data, host_resp_data}), 64'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'({host_cmd_ready, eng_resp_ready}), 64'(2'b11));
    check("rst_inflight", 64'(inflight_cnt), 64'(0));

    // 1: SET_MASK round trip
    tick();
    host_cmd_valid = 1'b1; host_cmd_funct = 7'd0; host_cmd_rd = 5'd1; host_cmd_xd = 1'b1;
    host_cmd_rs1_data = 32'hFF; host_cmd_rs2_data = 32'h0;
    exp_cmd.push_back('{7'd0, 5'd1, 32'hFF, 32'h0});
    @(negedge clk);
    check("t1_no_bypass", 64'(eng_cmd_valid), 64'(0));
    @(posedge clk);
    #1;
    host_cmd_valid = 1'b0;
    @(negedge clk);
    check("t1_issue_valid", 64'(eng_cmd_valid), 64'(1));
    check("t1_issue_rs1", 64'(eng_cmd_rs1_data), 64'(32'hFF));
    tick();
    eng_respond(5'd1, 32'h0, 1'b1);
    @(negedge clk);
    check("t1_resp_valid", 64'(host_resp_valid), 64'(1));
    check("t1_resp_rd", 64'(host_resp_rd), 64'(1));
    check("t1_busy_held", 64'({busy, inflight_cnt}), 64'({1'b1, 3'd1}));
    tick();
    host_resp_ready = 1'b1;
    tick();
    host_resp_ready = 1'b0;
    @(negedge clk);
    check("t1_busy_clear", 64'({busy, inflight_cnt, host_resp_valid}), 64'(0));

    // 2: command queue backpressure and order
    tick();
    eng_cmd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(7'd2, 5'(i), 1'b0, 32'(i), 32'h20 + 32'(i), 1'b1);
    @(negedge clk);
    check("t2_full_ready", 64'(host_cmd_ready), 64'(0));
    check("t2_head_rs1", 64'(eng_cmd_rs1_data), 64'(1));
    tick();
    fork
      push_cmd(7'd2, 5'd5, 1'b0, 32'd5, 32'h25, 1'b1);
      begin
        repeat (3) tick();
        check("t2_still_full", 64'(host_cmd_ready), 64'(0));
        eng_cmd_ready = 1'b1;
      end
    join
    wait_cmd_drain();
    wait_idle();

    // 3: credit limit
    for (int i = 1; i <= 6; i++) push_cmd(7'd3, 5'(i), 1'b1, 32'h30 + 32'(i), 32'h0, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("t3_inflight_max", 64'(inflight_cnt), 64'(4));
    check("t3_blocked", 64'(eng_cmd_valid), 64'(0));
    check("t3_pending", 64'(exp_cmd.size()), 64'(2));
    tick();
    for (int i = 1; i <= 4; i++) eng_respond(5'(i), 32'h100 + 32'(i), 1'b1);
    @(negedge clk);
    check("t3_resp_full", 64'({eng_resp_ready, host_resp_valid}), 64'(2'b01));
    tick();
    host_resp_ready = 1'b1;
    tick();
    host_resp_ready = 1'b0;
    @(negedge clk);
    check("t3_after_pop", 64'({inflight_cnt, eng_cmd_valid}), 64'({3'd3, 1'b1}));
    tick();
    @(negedge clk);
    check("t3_reblocked", 64'({inflight_cnt, eng_cmd_valid}), 64'({3'd4, 1'b0}));
    check("t3_one_left", 64'(exp_cmd.size()), 64'(1));
    tick();
    eng_respond(5'd5, 32'h105, 1'b1);
    host_resp_ready = 1'b1;
    wait_cmd_drain();
    eng_respond(5'd6, 32'h106, 1'b1);
    wait_idle();
    check("t3_resp_drain", 64'(exp_resp.size()), 64'(0));

    // 4: mixed xd
    host_resp_ready = 1'b0;
    push_cmd(7'd4, 5'd8, 1'b0, 32'h41, 32'h0, 1'b1);
    push_cmd(7'd5, 5'd7, 1'b1, 32'h42, 32'h0, 1'b1);
    wait_cmd_drain();
    @(negedge clk);
    check("t4_inflight", 64'(inflight_cnt), 64'(1));
    tick();
    eng_respond(5'd7, 32'h1E, 1'b1);
    @(negedge clk);
    check("t4_resp_data", 64'({host_resp_valid, host_resp_data}), 64'({1'b1, 32'h1E}));
    tick();
    host_resp_ready = 1'b1;
    wait_idle();
    repeat (2) tick();
    @(negedge clk);
    check("t4_one_resp", 64'({host_resp_valid, err_unexpected_resp}), 64'(0));
    check("t4_resp_drain", 64'(exp_resp.size()), 64'(0));

    // 5: unexpected response
    tick();
    host_resp_ready = 1'b0;
    eng_respond(5'd3, 32'h55, 1'b0);
    @(negedge clk);
    check("t5_err_set", 64'({err_unexpected_resp, host_resp_valid}), 64'(2'b10));
    repeat (3) tick();
    @(negedge clk);
    check("t5_err_sticky", 64'({err_unexpected_resp, host_resp_valid, inflight_cnt}),
          64'({1'b1, 1'b0, 3'd0}));

    // 6: reset mid-operation
    tick();
    push_cmd(7'd6, 5'd10, 1'b1, 32'h51, 32'h0, 1'b1);
    push_cmd(7'd6, 5'd11, 1'b1, 32'h52, 32'h0, 1'b1);
    wait_cmd_drain();
    eng_cmd_ready = 1'b0;
    eng_respond(5'd10, 32'hA0, 1'b1);
    eng_respond(5'd11, 32'hA1, 1'b1);
    for (int i = 0; i < 3; i++) push_cmd(7'd7, 5'(i), 1'b0, 32'h70 + 32'(i), 32'h0, 1'b0);
    @(negedge clk);
    check("t6_loaded", 64'({eng_cmd_valid, host_resp_valid, busy, inflight_cnt}),
          64'({1'b1, 1'b1, 1'b1, 3'd2}));
    tick();
    rst_n = 1'b0;
    exp_cmd.delete();
    exp_resp.delete();
    #1;
    check("t6_rst_valids", 64'({eng_cmd_valid, host_resp_valid}), 64'(0));
    check("t6_rst_state", 64'({inflight_cnt, err_unexpected_resp, busy}), 64'(0));
    check("t6_rst_data", 64'({eng_cmd_rs1_data, host_resp_rd}), 64'(0));
    tick();
    rst_n = 1'b1;
    eng_cmd_ready = 1'b1;
    @(negedge clk);
    check("t6_post_ready", 64'({host_cmd_ready, eng_resp_ready, eng_cmd_valid}), 64'(3'b110));
    tick();
    push_cmd(7'd1, 5'd9, 1'b1, 32'h61, 32'h62, 1'b1);
    wait_cmd_drain();
    eng_respond(5'd9, 32'h99, 1'b1);
    host_resp_ready = 1'b1;
    wait_idle();
    check("t6_final_drain", 64'(exp_resp.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
